// File: rtl/ej32_pkg.sv
// ej32_pkg: shared types and helpers for the EJ32 memory sequencer.
// Optional feature macro used by this slice: EJ32_MEM_SEXT_EN (sign-extending loads).
package ej32_pkg;

  // Transfer size as encoded on ls_sz.
  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } sz_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LS   = 2'd1,
    S_IF   = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  // Index of the last byte cycle (N-1) for a size.
  function automatic logic [1:0] last_k(input sz_t sz);
    case (sz)
      SZ_B:    last_k = 2'd0;
      SZ_H:    last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  endfunction

  // A size is rejected when reserved or wider than the datapath.
  function automatic logic size_err(input sz_t sz, input int nbytes);
    size_err = (sz == SZ_RSV) || ((int'(1) << sz) > nbytes);
  endfunction

endpackage

// File: rtl/ej32_be_lane.sv
// ej32_be_lane: big-endian byte lane for the memory sequencer.
// Picks the store byte for cycle k, shifts load bytes into the accumulator
// and extends the assembled load (sign extension only with EJ32_MEM_SEXT_EN).
module ej32_be_lane
  import ej32_pkg::*;
#(
  parameter int DSZ = 32
) (
  input  logic [DSZ-1:0] wd,
  input  sz_t            sz,
  input  logic [1:0]     k,
  output logic [7:0]     vo,
  input  logic [DSZ-1:0] acc,
  input  logic [7:0]     vi,
  input  logic           sx,
  output logic [DSZ-1:0] acc_shift,
  output logic [DSZ-1:0] rd
);

  localparam int NB = DSZ / 8;

  logic [7:0] wb [NB];
  logic [1:0] idx;
  logic [7:0] unused_acc;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      assign wb[gi] = wd[8*gi +: 8];
    end
  endgenerate

  // Byte k of an N-byte value is byte (N-1-k) counted from the LSB.
  assign idx = last_k(sz) - k;

  // Store byte mux.
  always_comb begin
    vo = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (idx == 2'(i)) vo = wb[i];
    end
  end

  // First byte read ends up most significant.
  assign acc_shift  = {acc[DSZ-9:0], vi};
  assign unused_acc = acc[DSZ-1 -: 8];

`ifdef EJ32_MEM_SEXT_EN
  // Sign-extend narrow loads when requested.
  always_comb begin
    rd = acc_shift;
    if (sx && (sz == SZ_B)) begin
      for (int i = 8; i < DSZ; i++) rd[i] = acc_shift[7];
    end else if (sx && (sz == SZ_H)) begin
      for (int i = 16; i < DSZ; i++) rd[i] = acc_shift[15];
    end
  end
`else
  logic unused_sx;
  assign unused_sx = sx;
  assign rd        = acc_shift;
`endif

endmodule

// File: rtl/ej32_mem_seq.sv
// ej32_mem_seq: byte-serial SRAM sequencer for EJ32 load/store and opcode fetch.
// Memory outputs are registered from the next-state decode so they are clean
// and forced to zero by reset. Optional macro: EJ32_MEM_SEXT_EN.
module ej32_mem_seq
  import ej32_pkg::*;
#(
  parameter int DSZ = 32,
  parameter int ASZ = 17
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ls_req,
  input  logic           ls_we,
  input  logic [1:0]     ls_sz,
  input  logic           ls_sx,
  input  logic [ASZ-1:0] ls_a,
  input  logic [DSZ-1:0] ls_wd,
  output logic           ls_ack,
  output logic           ls_err,
  output logic [DSZ-1:0] ls_rd,
  input  logic           if_req,
  input  logic [ASZ-1:0] if_a,
  output logic           if_ack,
  output logic [7:0]     if_d,
  output logic           bsy,
  output logic [ASZ-1:0] mem_a,
  output logic           mem_we,
  output logic [7:0]     mem_vo,
  input  logic [7:0]     mem_vi
);

  state_t         state_reg, state_next;
  logic [1:0]     k_reg, k_next;
  logic           we_reg, sx_reg, err_reg, is_if_reg;
  sz_t            sz_reg;
  logic [ASZ-1:0] a_reg;
  logic [DSZ-1:0] wd_reg, acc_reg, rd_reg;
  logic [7:0]     ifd_reg;
  logic [ASZ-1:0] mem_a_reg, mem_a_next;
  logic           mem_we_reg, mem_we_next;
  logic [7:0]     mem_vo_reg, mem_vo_next;
  logic           ls_accept, if_accept, req_err;
  logic [DSZ-1:0] sel_wd;
  sz_t            sel_sz;
  logic [1:0]     sel_k;
  logic [7:0]     lane_vo;
  logic [DSZ-1:0] lane_acc, lane_rd;

  ej32_be_lane #(.DSZ(DSZ)) u_lane (
    .wd        (sel_wd),
    .sz        (sel_sz),
    .k         (sel_k),
    .vo        (lane_vo),
    .acc       (acc_reg),
    .vi        (mem_vi),
    .sx        (sx_reg),
    .acc_shift (lane_acc),
    .rd        (lane_rd)
  );

  // Next state plus the memory port values for the coming cycle.
  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    mem_a_next  = if_a;
    mem_we_next = 1'b0;
    sel_wd      = wd_reg;
    sel_sz      = sz_reg;
    sel_k       = k_reg + 2'd1;
    ls_accept   = 1'b0;
    if_accept   = 1'b0;
    req_err     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (ls_req) begin
          ls_accept = 1'b1;
          if (size_err(sz_t'(ls_sz), DSZ / 8)) begin
            req_err    = 1'b1;
            state_next = S_ACK;
          end else begin
            state_next  = S_LS;
            k_next      = 2'd0;
            mem_a_next  = ls_a;
            mem_we_next = ls_we;
            sel_wd      = ls_wd;
            sel_sz      = sz_t'(ls_sz);
            sel_k       = 2'd0;
          end
        end else if (if_req) begin
          if_accept  = 1'b1;
          state_next = S_IF;
          mem_a_next = if_a;
        end
      end
      S_LS: begin
        if (k_reg == last_k(sz_reg)) begin
          state_next = S_ACK;
        end else begin
          k_next      = k_reg + 2'd1;
          mem_a_next  = a_reg + ASZ'(k_reg) + ASZ'(1);
          mem_we_next = we_reg;
        end
      end
      S_IF:    state_next = S_ACK;
      default: state_next = S_IDLE;
    endcase
    mem_vo_next = mem_we_next ? lane_vo : 8'h00;
  end

  // State, captured request, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      k_reg      <= 2'd0;
      we_reg     <= 1'b0;
      sx_reg     <= 1'b0;
      sz_reg     <= SZ_B;
      a_reg      <= '0;
      wd_reg     <= '0;
      acc_reg    <= '0;
      rd_reg     <= '0;
      err_reg    <= 1'b0;
      is_if_reg  <= 1'b0;
      ifd_reg    <= 8'h00;
      mem_a_reg  <= '0;
      mem_we_reg <= 1'b0;
      mem_vo_reg <= 8'h00;
    end else begin
      state_reg  <= state_next;
      k_reg      <= k_next;
      mem_a_reg  <= mem_a_next;
      mem_we_reg <= mem_we_next;
      mem_vo_reg <= mem_vo_next;
      if (ls_accept) begin
        we_reg    <= ls_we;
        sx_reg    <= ls_sx;
        sz_reg    <= sz_t'(ls_sz);
        a_reg     <= ls_a;
        wd_reg    <= ls_wd;
        err_reg   <= req_err;
        is_if_reg <= 1'b0;
        acc_reg   <= '0;
      end
      if (if_accept) begin
        is_if_reg <= 1'b1;
        err_reg   <= 1'b0;
      end
      if (state_reg == S_LS) begin
        acc_reg <= lane_acc;
        if ((k_reg == last_k(sz_reg)) && !we_reg) rd_reg <= lane_rd;
      end
      if (state_reg == S_IF) ifd_reg <= mem_vi;
    end
  end

  assign ls_ack = (state_reg == S_ACK) && !is_if_reg;
  assign ls_err = ls_ack && err_reg;
  assign if_ack = (state_reg == S_ACK) && is_if_reg;
  assign ls_rd  = rd_reg;
  assign if_d   = ifd_reg;
  assign bsy    = (state_reg != S_IDLE);
  assign mem_a  = mem_a_reg;
  assign mem_we = mem_we_reg;
  assign mem_vo = mem_vo_reg;

endmodule
